// File: rtl/clock_time_keeper_pkg.sv
// Shared types and BCD helpers for the HH:MM:SS timekeeping core.
// Each time field is a two-digit BCD pair that steps and wraps without any binary intermediate.
package clock_time_keeper_pkg;

  typedef enum logic [1:0] {
    ModeRun     = 2'b00,
    ModeSetHour = 2'b01,
    ModeSetMin  = 2'b10
  } set_mode_e;

  localparam logic [3:0] BcdMaxUnit  = 4'd9;
  localparam logic [3:0] BcdMaxTen   = 4'd5;
  localparam logic [3:0] HourMaxTen  = 4'd2;
  localparam logic [3:0] HourMaxUnit = 4'd3;

  typedef struct packed {
    logic [3:0] msd;
    logic [3:0] lsd;
  } bcd2_t;

  function automatic logic bcd2_at_max(bcd2_t v, logic [3:0] max_msd, logic [3:0] max_lsd);
    return (v.msd == max_msd) && (v.lsd == max_lsd);
  endfunction

  // Units roll 9->0 into the tens digit; the field's top value wraps the pair to 00.
  function automatic bcd2_t bcd2_step(bcd2_t v, logic [3:0] max_msd, logic [3:0] max_lsd);
    bcd2_t r;
    if (bcd2_at_max(v, max_msd, max_lsd)) begin
      r = '0;
    end else if (v.lsd == BcdMaxUnit) begin
      r.msd = v.msd + 4'd1;
      r.lsd = 4'd0;
    end else begin
      r.msd = v.msd;
      r.lsd = v.lsd + 4'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// Raw push-button to single-cycle press pulse: 2-FF synchronizer, stability counter, rising-edge pulse.
module button_debouncer #(
  parameter int unsigned DEBOUNCE_CYC = 1_000_000
) (
  input  logic CLK,
  input  logic RST,
  input  logic BtnIn,
  output logic Press
);

  localparam int unsigned CntW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYC - 1);

  logic            sync1_q, sync2_q;
  logic            level_q;
  logic            press_q;
  logic [CntW-1:0] cnt_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= BtnIn;
      sync2_q <= sync1_q;
      press_q <= 1'b0;
      if (sync2_q == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CntLast) begin
        // DEBOUNCE_CYC consecutive samples disagreed with the accepted level.
        level_q <= sync2_q;
        press_q <= sync2_q;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + CntW'(1);
      end
    end
  end

  assign Press = press_q;

endmodule

// File: rtl/clock_time_keeper.sv
// 24-hour BCD clock: 1 Hz prescaler, RUN/SET_HOUR/SET_MIN mode FSM and a BCD counter chain.
// All digit and mode outputs come straight from registers.
module clock_time_keeper
  import clock_time_keeper_pkg::*;
#(
  parameter int unsigned CLK_HZ       = 100_000_000,
  parameter int unsigned DEBOUNCE_CYC = 1_000_000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       BtnMode,
  input  logic       BtnInc,
  output logic [3:0] HourMSD,
  output logic [3:0] HourLSD,
  output logic [3:0] MinMSD,
  output logic [3:0] MinLSD,
  output logic [3:0] SecMSD,
  output logic [3:0] SecLSD,
  output logic [1:0] SetMode
);

  localparam int unsigned PrescW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PrescW-1:0] PrescLast = PrescW'(CLK_HZ - 1);

  logic mode_press, inc_press;

  button_debouncer #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_mode_db (
    .CLK  (CLK),
    .RST  (RST),
    .BtnIn(BtnMode),
    .Press(mode_press)
  );

  button_debouncer #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_inc_db (
    .CLK  (CLK),
    .RST  (RST),
    .BtnIn(BtnInc),
    .Press(inc_press)
  );

  set_mode_e         mode_q, mode_d;
  logic [PrescW-1:0] presc_q, presc_d;
  bcd2_t             hour_q, hour_d;
  bcd2_t             min_q, min_d;
  bcd2_t             sec_q, sec_d;
  logic              tick;

  always_comb begin
    mode_d  = mode_q;
    hour_d  = hour_q;
    min_d   = min_q;
    sec_d   = sec_q;
    tick    = (mode_q == ModeRun) && (presc_q == PrescLast);
    presc_d = tick ? '0 : presc_q + PrescW'(1);

    if (tick) begin
      sec_d = bcd2_step(sec_q, BcdMaxTen, BcdMaxUnit);
      if (bcd2_at_max(sec_q, BcdMaxTen, BcdMaxUnit)) begin
        min_d = bcd2_step(min_q, BcdMaxTen, BcdMaxUnit);
        if (bcd2_at_max(min_q, BcdMaxTen, BcdMaxUnit)) begin
          hour_d = bcd2_step(hour_q, HourMaxTen, HourMaxUnit);
        end
      end
    end

    // A mode press in the same cycle swallows any increment.
    if (mode_press) begin
      unique case (mode_q)
        ModeRun:     mode_d = ModeSetHour;
        ModeSetHour: mode_d = ModeSetMin;
        ModeSetMin: begin
          mode_d  = ModeRun;
          sec_d   = '0;
          presc_d = '0;
        end
        default:     mode_d = ModeRun;
      endcase
    end else if (inc_press) begin
      unique case (mode_q)
        ModeSetHour: hour_d = bcd2_step(hour_q, HourMaxTen, HourMaxUnit);
        ModeSetMin:  min_d  = bcd2_step(min_q, BcdMaxTen, BcdMaxUnit);
        default:     ;
      endcase
    end

    if (mode_d != ModeRun) begin
      presc_d = '0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      mode_q  <= ModeRun;
      presc_q <= '0;
      hour_q  <= '0;
      min_q   <= '0;
      sec_q   <= '0;
    end else begin
      mode_q  <= mode_d;
      presc_q <= presc_d;
      hour_q  <= hour_d;
      min_q   <= min_d;
      sec_q   <= sec_d;
    end
  end

  assign HourMSD = hour_q.msd;
  assign HourLSD = hour_q.lsd;
  assign MinMSD  = min_q.msd;
  assign MinLSD  = min_q.lsd;
  assign SecMSD  = sec_q.msd;
  assign SecLSD  = sec_q.lsd;
  assign SetMode = mode_q;

endmodule

// File: tb/tb_clock_time_keeper.sv
// Randomized bench for clock_time_keeper: a seconds-of-day reference model feeds a per-cycle
// expectation queue, and a negedge monitor pops and compares every registered output.
module tb_clock_time_keeper;

  localparam int unsigned ClkHz = 10;
  localparam int unsigned Deb   = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic [3:0] hour_msd, hour_lsd, min_msd, min_lsd, sec_msd, sec_lsd;
  logic [1:0] set_mode;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  clock_time_keeper #(
    .CLK_HZ      (ClkHz),
    .DEBOUNCE_CYC(Deb)
  ) dut (
    .CLK    (clk),
    .RST    (rst),
    .BtnMode(btn_mode),
    .BtnInc (btn_inc),
    .HourMSD(hour_msd),
    .HourLSD(hour_lsd),
    .MinMSD (min_msd),
    .MinLSD (min_lsd),
    .SecMSD (sec_msd),
    .SecLSD (sec_lsd),
    .SetMode(set_mode)
  );

  // Reference model: time as seconds since midnight, mode 0/1/2, prescaler count.
  typedef struct {
    bit old_s;  // raw sample two edges back
    bit new_s;  // raw sample one edge back
    bit acc;
    int run;
  } db_t;

  typedef struct {
    int secs;
    int mode;
  } snap_t;

  snap_t exp_q[$];
  int    m_secs, m_mode, m_presc;
  db_t   db_m, db_i;
  bit    mp, ip;

  function automatic db_t db_next(db_t s, bit raw, output bit press);
    bit seen;
    seen    = s.old_s;
    s.old_s = s.new_s;
    s.new_s = raw;
    press   = 1'b0;
    if (seen == s.acc) begin
      s.run = 0;
    end else begin
      s.run++;
      if (s.run == Deb) begin
        s.acc = seen;
        s.run = 0;
        press = seen;
      end
    end
    return s;
  endfunction

  task automatic model_reset();
    m_secs  = 0;
    m_mode  = 0;
    m_presc = 0;
    db_m    = '{old_s: 1'b0, new_s: 1'b0, acc: 1'b0, run: 0};
    db_i    = '{old_s: 1'b0, new_s: 1'b0, acc: 1'b0, run: 0};
    mp      = 1'b0;
    ip      = 1'b0;
  endtask

  task automatic model_step();
    bit tick;
    int nxt_presc, h, m, s;
    bit nmp, nip;
    tick      = (m_mode == 0) && (m_presc == ClkHz - 1);
    nxt_presc = tick ? 0 : m_presc + 1;
    if (tick) m_secs = (m_secs + 1) % 86400;
    h = m_secs / 3600;
    m = (m_secs / 60) % 60;
    s = m_secs % 60;
    if (mp) begin
      if (m_mode == 0) m_mode = 1;
      else if (m_mode == 1) m_mode = 2;
      else begin
        m_mode    = 0;
        m_secs    = h * 3600 + m * 60;
        nxt_presc = 0;
      end
    end else if (ip) begin
      if (m_mode == 1) m_secs = ((h + 1) % 24) * 3600 + m * 60 + s;
      else if (m_mode == 2) m_secs = h * 3600 + ((m + 1) % 60) * 60 + s;
    end
    if (m_mode != 0) nxt_presc = 0;
    m_presc = nxt_presc;
    db_m = db_next(db_m, btn_mode, nmp);
    db_i = db_next(db_i, btn_inc, nip);
    mp   = nmp;
    ip   = nip;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        model_reset();
        exp_q.delete();
      end else begin
        model_step();
      end
      exp_q.push_back('{secs: m_secs, mode: m_mode});
    end
  end

  // Monitor: outputs are registered, so every cycle presents a fresh value to check.
  initial begin
    snap_t e;
    logic [25:0] act, req;
    int h, m, s;
    forever begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        if ($time > 20) begin
          checks++;
          errors++;
          $display("FAIL scoreboard_empty at %0t: actual no expectation, required one", $time);
        end
      end else begin
        e   = exp_q.pop_front();
        h   = e.secs / 3600;
        m   = (e.secs / 60) % 60;
        s   = e.secs % 60;
        req = {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10),
               2'(e.mode)};
        act = {hour_msd, hour_lsd, min_msd, min_lsd, sec_msd, sec_lsd, set_mode};
        checks++;
        if (act !== req) begin
          errors++;
          $display("FAIL time_mode at %0t: actual %h%h:%h%h:%h%h mode %b, required %h%h:%h%h:%h%h mode %b",
                   $time, act[25:22], act[21:18], act[17:14], act[13:10], act[9:6], act[5:2],
                   act[1:0], req[25:22], req[21:18], req[17:14], req[13:10], req[9:6], req[5:2],
                   req[1:0]);
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input bit m, input bit i);
    btn_mode = m;
    btn_inc  = i;
    cyc(8);
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    cyc(8);
  endtask

  initial begin
    int guard;
    #2 rst = 1'b1;
    cyc(3);
    rst = 1'b0;

    // Reset mid-count, then the first second arrives ClkHz cycles after release.
    cyc(25);
    rst = 1'b1;
    cyc(3);
    rst = 1'b0;
    cyc(12);

    // Preload 23:59, run through the midnight wrap.
    press(1, 0);
    repeat (23) press(0, 1);
    press(1, 0);
    repeat (59) press(0, 1);
    press(1, 0);
    cyc(620);

    // Bouncing mode button, then a clean hold.
    repeat (3) begin
      btn_mode = 1'b1;
      cyc(1);
      btn_mode = 1'b0;
      cyc(1);
    end
    btn_mode = 1'b1;
    cyc(6);
    btn_mode = 1'b0;
    cyc(8);

    // Hour wrap at 23, then sixty minute increments.
    repeat (24) press(0, 1);
    press(1, 0);
    repeat (60) press(0, 1);

    // Simultaneous mode and inc with hours at 05.
    press(1, 0);
    press(1, 0);
    repeat (5) press(0, 1);
    press(1, 1);

    // Leave SET_MIN with seconds frozen at 37.
    press(1, 0);
    guard = 0;
    while ((m_secs % 60 != 37) && guard < 2000) begin
      cyc(1);
      guard++;
    end
    checks++;
    if (guard >= 2000) begin
      errors++;
      $display("FAIL wait_sec37: actual seconds %0d, required 37", m_secs % 60);
    end
    press(1, 0);
    press(1, 0);
    press(1, 0);
    cyc(3);
    press(0, 1);
    press(0, 1);
    cyc(20);

    // Random mix of presses, bounces, idles and resets.
    repeat (60) begin
      case ($urandom_range(0, 5))
        0: press(1, 0);
        1: press(0, 1);
        2: press(1, 1);
        3: begin
          repeat ($urandom_range(1, 8)) begin
            btn_mode = 1'($urandom);
            btn_inc  = 1'($urandom);
            cyc($urandom_range(1, 3));
          end
          btn_mode = 1'b0;
          btn_inc  = 1'b0;
          cyc(8);
        end
        4: cyc($urandom_range(1, 40));
        default: begin
          rst = 1'b1;
          cyc($urandom_range(1, 3));
          rst = 1'b0;
          cyc(2);
        end
      endcase
    end
    cyc(4);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
